// File: rtl/core_pkg.sv
// Shared core definitions: widths, writeback source select, load funct3 codes,
// and writeback FSM state encoding.
package core_pkg;

    localparam int unsigned CORE_DATA_WIDTH      = 32;
    localparam int unsigned CORE_REG_INDEX_WIDTH = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMem,
        StWrite,
        StError
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension, with a flag for
// illegal funct3 codes and misaligned half/word accesses.
module load_extend
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CORE_DATA_WIDTH
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ext_data,
    output logic                  illegal
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = mem_rdata[7:0];
        case (addr_lo)
            2'd0: byte_val = mem_rdata[7:0];
            2'd1: byte_val = mem_rdata[15:8];
            2'd2: byte_val = mem_rdata[23:16];
            2'd3: byte_val = mem_rdata[31:24];
            default: byte_val = mem_rdata[7:0];
        endcase
        half_val = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        ext_data = '0;
        illegal  = 1'b0;
        case (funct3)
            F3_LB:  ext_data = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
            F3_LBU: ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_val};
            F3_LH: begin
                ext_data = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
                illegal  = addr_lo[0];
            end
            F3_LHU: begin
                ext_data = {{(DATA_WIDTH-16){1'b0}}, half_val};
                illegal  = addr_lo[0];
            end
            F3_LW: begin
                ext_data = mem_rdata;
                illegal  = (addr_lo != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: picks the result source, waits for load data when needed,
// and issues a one-cycle registered write to the register file.
module writeback_unit
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = CORE_DATA_WIDTH,
    parameter int unsigned REG_INDEX_WIDTH = CORE_REG_INDEX_WIDTH,
    parameter int unsigned MEM_TIMEOUT     = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_start,
    input  logic [1:0]                 wb_sel,
    input  logic [REG_INDEX_WIDTH-1:0] rd_index,
    input  logic [2:0]                 funct3,
    input  logic [1:0]                 addr_lo,
    input  logic [DATA_WIDTH-1:0]      alu_result,
    input  logic [DATA_WIDTH-1:0]      pc_plus4,
    input  logic [DATA_WIDTH-1:0]      imm,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    input  logic                       mem_rvalid,
    output logic                       wb_busy,
    output logic                       wb_done,
    output logic                       wr_en,
    output logic [REG_INDEX_WIDTH-1:0] wr_reg_index,
    output logic [DATA_WIDTH-1:0]      wr_reg_data,
    output logic                       load_err
);

    wb_state_e                  state_q;
    logic [3:0]                 cnt_q;
    logic [REG_INDEX_WIDTH-1:0] rd_q;
    logic [2:0]                 f3_q;
    logic [1:0]                 alo_q;

    logic [2:0]            ext_f3;
    logic [1:0]            ext_alo;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_illegal;
    logic [DATA_WIDTH-1:0] sel_data;

    // In IDLE the extender checks the incoming command; afterwards it works on the latched one.
    assign ext_f3  = (state_q == StIdle) ? funct3  : f3_q;
    assign ext_alo = (state_q == StIdle) ? addr_lo : alo_q;

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extend (
        .funct3   (ext_f3),
        .addr_lo  (ext_alo),
        .mem_rdata(mem_rdata),
        .ext_data (ext_data),
        .illegal  (ext_illegal)
    );

    always_comb begin
        sel_data = alu_result;
        case (wb_sel_e'(wb_sel))
            WB_PC4:  sel_data = pc_plus4;
            WB_IMM:  sel_data = imm;
            default: sel_data = alu_result;
        endcase
    end

    assign wb_busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rd_q         <= '0;
            f3_q         <= '0;
            alo_q        <= '0;
            wb_done      <= 1'b0;
            wr_en        <= 1'b0;
            wr_reg_index <= '0;
            wr_reg_data  <= '0;
            load_err     <= 1'b0;
        end else begin
            wb_done  <= 1'b0;
            wr_en    <= 1'b0;
            load_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (wb_start) begin
                        rd_q  <= rd_index;
                        f3_q  <= funct3;
                        alo_q <= addr_lo;
                        cnt_q <= '0;
                        if (wb_sel_e'(wb_sel) == WB_MEM) begin
                            if (ext_illegal) begin
                                state_q  <= StError;
                                load_err <= 1'b1;
                                wb_done  <= 1'b1;
                            end else begin
                                state_q <= StWaitMem;
                            end
                        end else begin
                            state_q      <= StWrite;
                            wr_en        <= (rd_index != '0);
                            wb_done      <= 1'b1;
                            wr_reg_index <= rd_index;
                            wr_reg_data  <= sel_data;
                        end
                    end
                end
                StWaitMem: begin
                    if (mem_rvalid) begin
                        state_q      <= StWrite;
                        wr_en        <= (rd_q != '0);
                        wb_done      <= 1'b1;
                        wr_reg_index <= rd_q;
                        wr_reg_data  <= ext_data;
                    end else if (cnt_q == 4'(MEM_TIMEOUT - 1)) begin
                        state_q  <= StError;
                        load_err <= 1'b1;
                        wb_done  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage of the multi-cycle RISC-V core; sits directly upstream of the register file write port.
- On a start pulse from the control FSM, selects the result source: ALU, data memory, PC+4 or immediate.
- For loads, waits for memory read data, then aligns and sign/zero-extends it.
- Drives a single-cycle registered write strobe, index and data to the register file, which samples on the falling clock edge.

Parameters:
DATA_WIDTH, 32, width of result and register data
REG_INDEX_WIDTH, 5, register index width
MEM_TIMEOUT, 15, max cycles to wait for mem_rvalid before error; 4-bit counter

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
wb_start  input  1  one-cycle pulse: latch command and operands
wb_sel  input  2  source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM
rd_index  input  REG_INDEX_WIDTH  destination register
funct3  input  3  load type (used only for MEM)
addr_lo  input  2  low bits of load address
alu_result  input  DATA_WIDTH  ALU output
pc_plus4  input  DATA_WIDTH  link value
imm  input  DATA_WIDTH  immediate (LUI)
mem_rdata  input  DATA_WIDTH  data memory read word
mem_rvalid  input  1  mem_rdata valid this cycle
wb_busy  output  1  unit not IDLE
wb_done  output  1  one-cycle pulse: writeback finished, write or error
wr_en  output  1  register file write enable
wr_reg_index  output  REG_INDEX_WIDTH  register file write index
wr_reg_data  output  DATA_WIDTH  register file write data
load_err  output  1  one-cycle pulse: misaligned or illegal load, or memory timeout

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0:
  - State forced to IDLE.
  - All outputs 0, timeout counter 0.
  - Reset mid-operation abandons the command with no write.
- States: IDLE, WAIT_MEM, WRITE, ERROR.
- IDLE, wb_start=1:
  - Latch wb_sel, rd_index, funct3, addr_lo, and the selected operand.
  - Non-MEM -> WRITE.
  - MEM with legal, aligned load -> WAIT_MEM.
  - MEM with illegal funct3 (011, 110, 111), LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0 -> ERROR.
- wb_start while busy: ignored.
- mem_rvalid outside WAIT_MEM: ignored.
- WAIT_MEM:
  - mem_rvalid=1 -> capture the extended load value, go to WRITE.
  - Otherwise increment the counter; at MEM_TIMEOUT consecutive cycles without rvalid -> ERROR.
- WRITE, exactly one cycle:
  - wr_en=1 unless rd_index==0; for x0, wr_en=0 and wr_reg_index/wr_reg_data are still driven.
  - wb_done=1, then -> IDLE.
- ERROR, exactly one cycle: load_err=1, wb_done=1, wr_en=0, -> IDLE.
- Latency:
  - Non-MEM: wb_start at cycle N -> wr_en at N+1.
  - MEM: mem_rvalid at cycle M -> wr_en at M+1.
  - Outputs are registered, so data is stable at the register file's negedge sample.
- Load extension, byte/half chosen by addr_lo:
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
- wr_reg_index/wr_reg_data hold their last value outside WRITE; wr_en is 0 outside WRITE.
- Back-to-back: wb_start may arrive in the cycle after wb_done (IDLE).

Decomposition:
- Shared package core_pkg:
  - wb_sel encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM).
  - funct3 load encodings.
  - State encoding.
  - DATA_WIDTH/REG_INDEX_WIDTH constants shared with the register file.
- One natural sub-module, load_extend: purely combinational.
  - Inputs: funct3, addr_lo, mem_rdata.
  - Outputs: extended data and an illegal/misaligned flag.
  - Reused by the memory stage.

Test Plan:
- ALU writeback:
  - Stimulus: wb_start, wb_sel=00, rd=5, alu_result=0x0000_1234.
  - Expected: next cycle wr_en=1, index=5, data=0x0000_1234, wb_done=1; following cycle wr_en=0, busy=0.
- Signed byte load:
  - Stimulus: wb_sel=01, funct3=000, addr_lo=2, rd=7; mem_rvalid after 3 cycles with mem_rdata=0x1280_7F00.
  - Expected: data=0xFFFF_FF80, wr_en one cycle after rvalid.
  - Repeat with LBU: data=0x0000_0080.
- Misaligned / illegal loads:
  - LW with addr_lo=1 -> next cycle load_err=1, wb_done=1, wr_en=0.
  - funct3=011 -> same response.
- Timeout:
  - Stimulus: MEM load, mem_rvalid held 0.
  - Expected: load_err and wb_done after 15 WAIT_MEM cycles, no write.
  - A late mem_rvalid afterwards is ignored.
- x0 and busy:
  - wb_sel=11, rd=0, imm=0xABCD_E000 -> wb_done=1, wr_en=0.
  - A second wb_start during WAIT_MEM is ignored; the original load completes with its own rd.
- Async reset:
  - Stimulus: rst low in WAIT_MEM.
  - Expected: outputs 0 immediately; subsequent mem_rvalid produces no write; a new ALU command works after reset release.
